// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Constants shared by the 7-segment scanner and the formatting logic that
//   feeds it. Patterns are active-low, bit order {dp, g, f, e, d, c, b, a},
//   so an all-ones byte is a fully dark digit.
//   The scanner only uses SEG_OFF_DEFAULT. The decode helper is for upstream
//   consumers; the scanner itself never decodes.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int SEG_BITS = 8;

    // Pattern driven on the segment pins while a digit is dark
    localparam logic [SEG_BITS-1:0] SEG_OFF_DEFAULT = 8'hFF;

    // Special glyphs
    localparam logic [SEG_BITS-1:0] SEG_BLANK = 8'hFF;
    localparam logic [SEG_BITS-1:0] SEG_DASH  = 8'hBF;  // segment g only
    localparam logic [SEG_BITS-1:0] SEG_DP    = 8'h7F;  // decimal point only

    // Hex digit glyphs 0-F
    localparam logic [SEG_BITS-1:0] SEG_HEX_0 = 8'hC0;
    localparam logic [SEG_BITS-1:0] SEG_HEX_1 = 8'hF9;
    localparam logic [SEG_BITS-1:0] SEG_HEX_2 = 8'hA4;
    localparam logic [SEG_BITS-1:0] SEG_HEX_3 = 8'hB0;
    localparam logic [SEG_BITS-1:0] SEG_HEX_4 = 8'h99;
    localparam logic [SEG_BITS-1:0] SEG_HEX_5 = 8'h92;
    localparam logic [SEG_BITS-1:0] SEG_HEX_6 = 8'h82;
    localparam logic [SEG_BITS-1:0] SEG_HEX_7 = 8'hF8;
    localparam logic [SEG_BITS-1:0] SEG_HEX_8 = 8'h80;
    localparam logic [SEG_BITS-1:0] SEG_HEX_9 = 8'h90;
    localparam logic [SEG_BITS-1:0] SEG_HEX_A = 8'h88;
    localparam logic [SEG_BITS-1:0] SEG_HEX_B = 8'h83;
    localparam logic [SEG_BITS-1:0] SEG_HEX_C = 8'hC6;
    localparam logic [SEG_BITS-1:0] SEG_HEX_D = 8'hA1;
    localparam logic [SEG_BITS-1:0] SEG_HEX_E = 8'h86;
    localparam logic [SEG_BITS-1:0] SEG_HEX_F = 8'h8E;

    // Nibble to glyph, for formatting logic upstream of the scanner
    function automatic logic [SEG_BITS-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_BITS-1:0] seg;
        case (nib)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/refresh_tick.sv
// -----------------------------------------------------------------------------
// refresh_tick
//   Prescaler for the display scanner. Counts 0..DIV-1 and asserts tick for
//   the single cycle in which the count equals DIV-1, then wraps to 0.
//   DIV=1 yields a tick on every cycle.
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-low reset (count returns to 0)
//   tick  out  one-cycle refresh tick
// -----------------------------------------------------------------------------
module refresh_tick
    import seven_seg_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed driver for a common-enable bank of NUM_DIGITS 7-segment
//   digits, running entirely on clk with an internal refresh tick.
//   Each digit owns a slot of 2**BRIGHT_W ticks; within a slot the digit is
//   lit while phase < duty, which gives PWM brightness and always leaves the
//   last tick of a slot dark. Digit data is double-buffered: load fills the
//   pending bank, and the pending bank moves to the active bank only at a
//   frame boundary, so a frame never shows a mix of old and new data.
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   digits_in   in   digit i at [i*SEG_W +: SEG_W]
//   blank_in    in   1 = digit i forced dark
//   load        in   one-cycle strobe, captures digits_in/blank_in to pending
//   brightness  in   on-ticks per slot, sampled at each frame boundary
//   enable      out  digit select (active-low when EN_LOW=1)
//   out         out  segment pattern, SEG_OFF while dark
//   frame_done  out  one-cycle pulse, first cycle of each new frame
// -----------------------------------------------------------------------------
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int               NUM_DIGITS = 4,
    parameter int               SEG_W      = 8,
    parameter int               DIV        = 50000,
    parameter int               BRIGHT_W   = 3,
    parameter logic [SEG_W-1:0] SEG_OFF    = SEG_W'(SEG_OFF_DEFAULT),
    parameter bit               EN_LOW     = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       blank_in,
    input  logic                        load,
    input  logic [BRIGHT_W-1:0]         brightness,
    output logic [NUM_DIGITS-1:0]       enable,
    output logic [SEG_W-1:0]            out,
    output logic                        frame_done
);

    localparam int                    SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]     SLOT_ONE  = SLOT_W'(1);
    localparam logic [BRIGHT_W-1:0]   PHASE_MAX = '1;
    localparam logic [BRIGHT_W-1:0]   PHASE_ONE = BRIGHT_W'(1);
    localparam logic [NUM_DIGITS-1:0] EN_IDLE   = EN_LOW ? {NUM_DIGITS{1'b1}} : '0;

    // Refresh tick
    logic tick;

    refresh_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Scan counters
    logic [BRIGHT_W-1:0] phase_q, phase_d;
    logic [SLOT_W-1:0]   slot_q,  slot_d;
    logic                boundary;

    // Pending / active digit banks and brightness
    logic [SEG_W-1:0]      pend_dig_q [NUM_DIGITS];
    logic [SEG_W-1:0]      pend_dig_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [SEG_W-1:0]      act_dig_q  [NUM_DIGITS];
    logic [SEG_W-1:0]      act_dig_d  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic [BRIGHT_W-1:0]   duty_q, duty_d;

    // Output registers
    logic [NUM_DIGITS-1:0] enable_q, enable_d;
    logic [SEG_W-1:0]      out_q, out_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  lit;

    // The last tick of the last slot closes the frame
    assign boundary = tick && (phase_q == PHASE_MAX) && (slot_q == SLOT_LAST);

    always_comb begin
        phase_d = phase_q;
        slot_d  = slot_q;
        if (tick) begin
            phase_d = phase_q + PHASE_ONE;
            if (phase_q == PHASE_MAX) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_ONE;
            end
        end
    end

    // Bank update. The boundary copy reads the old pending contents, so a
    // load landing on the boundary cycle waits for the following boundary.
    always_comb begin
        pend_dig_d   = pend_dig_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_dig_d    = act_dig_q;
        act_blank_d  = act_blank_q;
        duty_d       = duty_q;

        if (boundary) begin
            duty_d       = brightness;
            pend_valid_d = 1'b0;
            if (pend_valid_q) begin
                act_dig_d   = pend_dig_q;
                act_blank_d = pend_blank_q;
            end
        end

        if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pend_dig_d[i] = digits_in[i*SEG_W +: SEG_W];
            end
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end
    end

    // Outputs are computed from next-state values so the registered pins
    // line up with the counters: the frame_done cycle already shows slot 0
    // of the new frame with the new bank and duty.
    always_comb begin
        lit          = (phase_d < duty_d) && !act_blank_d[slot_d];
        onehot       = '0;
        onehot[slot_d] = 1'b1;
        enable_d     = EN_IDLE;
        out_d        = SEG_OFF;
        if (lit) begin
            enable_d = EN_LOW ? ~onehot : onehot;
            out_d    = act_dig_d[slot_d];
        end
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q      <= '0;
            slot_q       <= '0;
            pend_blank_q <= '1;
            pend_valid_q <= 1'b0;
            act_blank_q  <= '1;
            duty_q       <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pend_dig_q[i] <= SEG_OFF;
                act_dig_q[i]  <= SEG_OFF;
            end
        end else begin
            phase_q      <= phase_d;
            slot_q       <= slot_d;
            pend_dig_q   <= pend_dig_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            act_dig_q    <= act_dig_d;
            act_blank_q  <= act_blank_d;
            duty_q       <= duty_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q     <= EN_IDLE;
            out_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            out_q        <= out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign enable     = enable_q;
    assign out        = out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

    localparam int ND        = 4;
    localparam int SW        = 8;
    localparam int DV        = 4;
    localparam int BW        = 2;
    localparam int PHASES    = 1 << BW;
    localparam int SLOT_CLK  = DV * PHASES;
    localparam int FRAME_CLK = SLOT_CLK * ND;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic [ND*SW-1:0]  digits_in  = '0;
    logic [ND-1:0]     blank_in   = '0;
    logic              load       = 1'b0;
    logic [BW-1:0]     brightness = '0;
    logic [ND-1:0]     enable;
    logic [SW-1:0]     out;
    logic              frame_done;

    seven_seg_scanner #(
        .NUM_DIGITS (ND),
        .SEG_W      (SW),
        .DIV        (DV),
        .BRIGHT_W   (BW),
        .SEG_OFF    (8'hFF),
        .EN_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .blank_in   (blank_in),
        .load       (load),
        .brightness (brightness),
        .enable     (enable),
        .out        (out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: state plus the count of clock edges since reset release
    logic [ND*SW-1:0] m_pend, m_act;
    logic [ND-1:0]    m_pendb, m_actb;
    bit               m_pv;
    int               m_duty;
    int               m_c;
    logic [ND-1:0]    exp_en;
    logic [SW-1:0]    exp_out;
    logic             exp_fd;

    logic [ND-1:0]    cap_en  [FRAME_CLK];
    logic [SW-1:0]    cap_out [FRAME_CLK];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = {ND{8'hFF}};
        m_act   = {ND{8'hFF}};
        m_pendb = '1;
        m_actb  = '1;
        m_pv    = 1'b0;
        m_duty  = 0;
        m_c     = 0;
        exp_en  = 4'hF;
        exp_out = 8'hFF;
        exp_fd  = 1'b0;
    endtask

    task automatic model_step();
        int pos, slot, phase;
        bit bnd, lit;
        logic [ND-1:0] oh;
        bnd = ((m_c % FRAME_CLK) == FRAME_CLK - 1);
        if (bnd) begin
            if (m_pv) begin
                m_act  = m_pend;
                m_actb = m_pendb;
            end
            m_pv   = 1'b0;
            m_duty = int'(brightness);
        end
        if (load) begin
            m_pend  = digits_in;
            m_pendb = blank_in;
            m_pv    = 1'b1;
        end
        m_c++;
        pos   = m_c % FRAME_CLK;
        slot  = pos / SLOT_CLK;
        phase = (pos % SLOT_CLK) / DV;
        lit   = (phase < m_duty) && !m_actb[slot];
        oh    = 4'b0001 << slot;
        exp_en  = lit ? ~oh : 4'hF;
        exp_out = lit ? m_act[slot*SW +: SW] : 8'hFF;
        exp_fd  = bnd;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("enable", 32'(enable), 32'(exp_en));
                check("out", 32'(out), 32'(exp_out));
                check("frame_done", 32'(frame_done), 32'(exp_fd));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        digits_in = d;
        blank_in  = b;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Waits for frame_done, then records one whole frame starting at that cycle
    task automatic capture_frame();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 3 * FRAME_CLK);
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL frame_wait: got no frame_done, expected one within %0d cycles", 3 * FRAME_CLK);
        end
        cap_en[0]  = enable;
        cap_out[0] = out;
        for (int k = 1; k < FRAME_CLK; k++) begin
            @(posedge clk);
            #1;
            cap_en[k]  = enable;
            cap_out[k] = out;
        end
    endtask

    task automatic check_cap(input string name, input int k, input logic [3:0] en, input logic [7:0] o);
        check({name, "_en"}, 32'(cap_en[k]), 32'(en));
        check({name, "_out"}, 32'(cap_out[k]), 32'(o));
    endtask

    function automatic int dark_count();
        int nbad;
        nbad = 0;
        for (int k = 0; k < FRAME_CLK; k++) begin
            if (cap_en[k] !== 4'hF || cap_out[k] !== 8'hFF) nbad++;
        end
        return nbad;
    endfunction

    initial begin
        int n;
        int r;
        logic [31:0] da, db;
        da = 32'h9299B0A4;
        db = 32'hB0A4F9C0;

        // 1: reset state and first frame boundary
        brightness = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", 32'(enable), 32'h0000000F);
        check("rst_out", 32'(out), 32'h000000FF);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 200);
        check("first_frame_done_latency", 32'(n), 32'd64);

        // 2: full brightness scan pattern
        do_load(32'h88442211, 4'b0000);
        capture_frame();
        check_cap("b3_k0", 0, 4'b1110, 8'h11);
        check_cap("b3_k11", 11, 4'b1110, 8'h11);
        check_cap("b3_k12", 12, 4'hF, 8'hFF);
        check_cap("b3_k15", 15, 4'hF, 8'hFF);
        check_cap("b3_k16", 16, 4'b1101, 8'h22);
        check_cap("b3_k32", 32, 4'b1011, 8'h44);
        check_cap("b3_k48", 48, 4'b0111, 8'h88);
        check_cap("b3_k59", 59, 4'b0111, 8'h88);
        check_cap("b3_k60", 60, 4'hF, 8'hFF);

        // 3: brightness change only at the boundary; brightness 0 is dark
        wait_cycles(20);
        brightness = 2'd1;
        wait_cycles(6);
        check("mid_frame_bright_hold", 32'(enable), 32'b1101);
        capture_frame();
        check_cap("b1_k0", 0, 4'b1110, 8'h11);
        check_cap("b1_k3", 3, 4'b1110, 8'h11);
        check_cap("b1_k4", 4, 4'hF, 8'hFF);
        check_cap("b1_k16", 16, 4'b1101, 8'h22);
        check_cap("b1_k20", 20, 4'hF, 8'hFF);
        wait_cycles(10);
        brightness = 2'd0;
        capture_frame();
        check("b0_dark_cycles", 32'(dark_count()), 32'd0);

        // 4: per-digit blanking
        brightness = 2'd3;
        wait_cycles(10);
        do_load(32'h88442211, 4'b0100);
        capture_frame();
        check_cap("blank_k0", 0, 4'b1110, 8'h11);
        check_cap("blank_k16", 16, 4'b1101, 8'h22);
        check_cap("blank_k32", 32, 4'hF, 8'hFF);
        check_cap("blank_k35", 35, 4'hF, 8'hFF);
        check_cap("blank_k48", 48, 4'b0111, 8'h88);

        // 5: load on the boundary cycle, then a second load mid-frame
        do_load(da, 4'b0000);
        capture_frame();
        check_cap("bload_k0", 0, 4'b1110, 8'hA4);
        check_cap("bload_k48", 48, 4'b0111, 8'h92);
        wait_cycles(20);
        check("bload_hold_en", 32'(enable), 32'b1101);
        check("bload_hold_out", 32'(out), 32'hB0);
        do_load(db, 4'b0000);
        capture_frame();
        check_cap("second_k0", 0, 4'b1110, 8'hC0);
        check_cap("second_k16", 16, 4'b1101, 8'hF9);
        check_cap("second_k32", 32, 4'b1011, 8'hA4);

        // 6: asynchronous reset in slot 2
        wait_cycles(35);
        check("pre_reset_en", 32'(enable), 32'b1011);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_en", 32'(enable), 32'h0000000F);
        check("async_rst_out", 32'(out), 32'h000000FF);
        check("async_rst_fd", 32'(frame_done), 32'h0);
        wait_cycles(2);
        rst = 1'b1;
        capture_frame();
        check("post_reset_dark_cycles", 32'(dark_count()), 32'd0);
        do_load(db, 4'b0000);
        capture_frame();
        check_cap("reload_k0", 0, 4'b1110, 8'hC0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            load = 1'b0;
            r = int'($urandom_range(0, 199));
            if (r < 8 || ((m_c % FRAME_CLK) == FRAME_CLK - 1 && $urandom_range(0, 1) == 1)) begin
                digits_in = $urandom;
                blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                load      = 1'b1;
            end
            if (r >= 100 && r < 104) brightness = 2'($urandom_range(0, 3));
            if (r == 199 && $urandom_range(0, 3) == 0) begin
                load = 1'b0;
                #2;
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        wait_cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
